// File: rtl/fread_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fread_arbiter
// Purpose  : Two-client arbiter/sequencer for the single spi_fread
//            request/response channel. Accepts whole-transfer requests from
//            two loaders, grants round-robin, issues one upstream request per
//            grant, steers the returned byte stream to the granted client,
//            counts bytes to completion and aborts on a response stall.
// Ports    : clk, rst_n (async, active-low)
//            c0_*/c1_* req_valid/req_ready/file_id/offset/len : client requests
//            c0_*/c1_* resp_valid/done/err, resp_data          : client responses
//            up_req_*  : upstream request (registered, held until ready)
//            up_resp_* : upstream response byte stream
//            busy, grant : status
// Revision : 1.0 - initial release
// ============================================================================
module fread_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  // client 0
  input  logic        c0_req_valid,
  output logic        c0_req_ready,
  input  logic [31:0] c0_file_id,
  input  logic [31:0] c0_offset,
  input  logic [10:0] c0_len,
  output logic        c0_resp_valid,
  output logic        c0_done,
  output logic        c0_err,
  // client 1
  input  logic        c1_req_valid,
  output logic        c1_req_ready,
  input  logic [31:0] c1_file_id,
  input  logic [31:0] c1_offset,
  input  logic [10:0] c1_len,
  output logic        c1_resp_valid,
  output logic        c1_done,
  output logic        c1_err,
  // shared response byte
  output logic [7:0]  resp_data,
  // upstream spi_fread channel
  output logic        up_req_valid,
  input  logic        up_req_ready,
  output logic [31:0] up_req_file_id,
  output logic [31:0] up_req_offset,
  output logic [10:0] up_req_len,
  input  logic [7:0]  up_resp_data,
  input  logic        up_resp_valid,
  // status
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [10:0] byte_cnt;
  logic [23:0] timer;

  logic        winner;
  logic        accept;
  logic        byte_in;
  logic        last_byte;
  logic        timeout_hit;

  // On a tie the client that did not win last time goes first; otherwise the
  // single requester wins. last_grant resets to 1 so client 0 wins the first tie.
  assign winner      = (c0_req_valid && c1_req_valid) ? ~last_grant : c1_req_valid;
  assign accept      = (state == IDLE) && (c0_req_valid || c1_req_valid);
  assign byte_in     = (state == STREAM) && up_resp_valid;
  assign last_byte   = byte_in && (byte_cnt == up_req_len);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == STREAM) && !up_resp_valid && (timer == TIMEOUT - 24'd1);

  assign c0_req_ready  = accept && !winner;
  assign c1_req_ready  = accept &&  winner;

  assign resp_data     = up_resp_data;
  assign c0_resp_valid = byte_in && !grant;
  assign c1_resp_valid = byte_in &&  grant;

  // DONE lasts exactly one cycle, so decoding it yields the completion pulse.
  assign c0_done       = (state == DONE) && !grant;
  assign c1_done       = (state == DONE) &&  grant;
  assign c0_err        = timeout_hit && !grant;
  assign c1_err        = timeout_hit &&  grant;

  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      up_req_valid   <= 1'b0;
      up_req_file_id <= 32'd0;
      up_req_offset  <= 32'd0;
      up_req_len     <= 11'd0;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      byte_cnt       <= 11'd0;
      timer          <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant          <= winner;
            last_grant     <= winner;
            up_req_file_id <= winner ? c1_file_id : c0_file_id;
            up_req_offset  <= winner ? c1_offset  : c0_offset;
            up_req_len     <= winner ? c1_len     : c0_len;
            byte_cnt       <= 11'd0;
            up_req_valid   <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (up_req_ready) begin
            up_req_valid <= 1'b0;
            timer        <= 24'd0;
            state        <= STREAM;
          end
        end

        STREAM: begin
          if (up_resp_valid) begin
            timer <= 24'd0;
            // The counter stops on the last byte so a 2048-byte transfer
            // never wraps it.
            if (last_byte) begin
              state <= DONE;
            end else begin
              byte_cnt <= byte_cnt + 11'd1;
            end
          end else if (timeout_hit) begin
            timer <= 24'd0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fread_arbiter.md
# fread_arbiter

Two-client arbiter and sequencer for the single spi_fread request/response channel to the ESP32. It accepts whole-transfer requests (file ID, offset, length) from two loaders, grants the channel round-robin, and issues one upstream request per grant. It then steers the returned byte stream to the granted client, counts bytes to completion, and aborts with an error on a response stall. RAM loaders and other fread consumers sit on the client side; the spi_fread core sits upstream.

## Interface
Parameters:
- TIMEOUT, 24'd1_000_000: max cycles allowed between consecutive response bytes in STREAM (first byte included); width 24.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- c0_req_valid, c1_req_valid  in  1  client request pending; held until accepted
- c0_req_ready, c1_req_ready  out  1  request accepted this cycle (combinational)
- c0_file_id, c1_file_id  in  32  file ID
- c0_offset, c1_offset  in  32  byte offset in file
- c0_len, c1_len  in  11  transfer length minus 1 (1..2048 bytes)
- c0_resp_valid, c1_resp_valid  out  1  byte for this client on resp_data
- resp_data  out  8  shared response byte, passthrough of up_resp_data
- c0_done, c1_done  out  1  one-cycle pulse: all bytes delivered
- c0_err, c1_err  out  1  one-cycle pulse: transfer aborted on timeout
- up_req_valid  out  1  upstream request valid (registered)
- up_req_ready  in  1  upstream accepted request
- up_req_file_id  out  32  latched file ID
- up_req_offset  out  32  latched offset
- up_req_len  out  11  latched length minus 1
- up_resp_data  in  8  upstream response byte
- up_resp_valid  in  1  upstream response byte valid
- busy  out  1  state != IDLE
- grant  out  1  client of current/last transfer (0 or 1)

## Operation
- States: IDLE, ISSUE, STREAM, DONE.
- IDLE, no valid request: stay.
- IDLE, exactly one cX_req_valid: that client wins.
- IDLE, both valid: the client != last_grant wins.
- IDLE, on a win: cX_req_ready=1 for the winner only; latch file_id/offset/len; grant and last_grant <= winner; byte counter <= 0; -> ISSUE.
- ISSUE: up_req_valid=1, fields stable. On up_req_ready=1: drop up_req_valid next cycle, clear timer, -> STREAM.
- STREAM: cX_resp_valid = up_resp_valid for the granted client only; the other client stays 0.
  - Each valid byte increments the counter (11-bit) and clears the timer.
  - Byte with counter == latched len: -> DONE.
  - Otherwise the timer increments every cycle. Timer == TIMEOUT-1 with no byte: pulse cX_err for the granted client, -> IDLE.
- DONE: cX_done=1 for one cycle, -> IDLE.
- up_resp_valid outside STREAM: ignored; no client valid, no counter change.
- Bytes beyond len in the same cycle cannot occur: at most one byte per cycle, and the exit happens on the last byte.
- Client request fields are sampled only on the accept cycle; later changes have no effect.

## Timing
- Reset (async, rst_n=0): state IDLE; up_req_valid=0; all cX_req_ready, cX_resp_valid, cX_done, cX_err = 0; busy=0; grant=0; last_grant=1 so client 0 wins the first tie; latched fields, counter and timer = 0.
- Accept to up_req_valid=1: 1 cycle.
- Response steering is combinational: zero-latency from up_resp_valid to cX_resp_valid.
- Last byte at cycle t: cX_done at t+1; IDLE at t+2, so a new accept is possible at t+2.
- Minimum gap between transfers: 1 DONE cycle plus the accept cycle in IDLE.
- Reset asserted mid-transfer: immediate return to IDLE with no done or err pulse; upstream recovery is the upstream owner's responsibility.
- Simultaneous up_resp_valid and timeout expiry: the byte wins; timer clears, no err.
- Len 0 is a 1-byte transfer; len 11'h7FF is a 2048-byte transfer; the counter never wraps.

## Test plan
- Single request: c0 requests file 0xDABBAD00, offset 0x800, len 3. Expect: up_req fields match one cycle after accept; 4 bytes A0..A3 appear on c0_resp_valid only; c0_done pulses once, 1 cycle after A3; busy falls.
- Tie after reset: c0 and c1 valid in the same cycle. Expect: c0 granted first. c1_req_ready stays 0 until c0_done; c1 is accepted 1 cycle later.
- Round-robin: both clients keep requesting for 4 transfers. Expect grant sequence 0,1,0,1.
- Upstream backpressure: up_req_ready held low 10 cycles. Expect up_req_valid held high with stable fields; STREAM entered the cycle after ready.
- Timeout: TIMEOUT=16; deliver 2 of 5 bytes then stall. Expect c0_err pulse 16 cycles after the last byte, no c0_done, IDLE next. Stray up_resp_valid afterwards reaches no client.
- Mid-transfer reset: assert rst_n=0 after 100 of 2048 bytes (len 11'h7FF). Expect all outputs at reset values immediately. A new full 2048-byte request then completes with exactly one done.
